router_rx_port: RTL and testbench

//  Drains one router output port (vld_out_x/data_out_x/read_enb_x), one instance per port, downstream of the router top.

---
 rtl/router_rx_pkg.sv | 27 ++
 rtl/router_rx_buf.sv | 56 +++++
 rtl/router_rx_port.sv | 184 ++++++++++++++++++
 tb/tb_router_rx_port.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_rx_pkg.sv
// Shared types and header-field constants for the router receive port.
package router_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_WAIT,
    PAYLOAD,
    PAR_RD,
    PAR_CHK
  } rx_state_e;

  localparam int ADDR_W  = 2;
  localparam int LEN_MSB = 7;
  localparam int LEN_LSB = ADDR_W;
  localparam int LEN_W   = LEN_MSB - LEN_LSB + 1;

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [7:0] data;
  } rx_entry_t;

  function automatic logic [LEN_W-1:0] hdr_len(input logic [7:0] hdr);
    return hdr[LEN_MSB:LEN_LSB];
  endfunction

endpackage

// File: rtl/router_rx_buf.sv
// Two-entry first-word-fall-through FIFO holding {sop, eop, data} entries.
module router_rx_buf
  import router_rx_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  rx_entry_t  wdata_i,
  input  logic       pop_i,
  output rx_entry_t  rdata_o,
  output logic       full_o,
  output logic       empty_o,
  output logic [1:0] count_o
);

  rx_entry_t  mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic       do_push;
  logic       do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  // a full buffer still takes a write when the head leaves in the same cycle
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;

  assert property (@(posedge clk) disable iff (rst)
                   !(push_i && (count_q == 2'(DEPTH)) && !do_pop));

endmodule

// File: rtl/router_rx_port.sv
// Drains one router output port: reassembles header/payload/parity packets,
// checks parity and forwards header+payload on a valid/ready stream.
//  state    | meaning
//  IDLE     | waiting for a packet, header read issued on entry to HDR_WAIT
//  HDR_WAIT | header byte arriving; latch length and seed parity
//  PAYLOAD  | reading and forwarding payload bytes
//  PAR_RD   | issue read for the parity byte
//  PAR_CHK  | parity byte arriving; compare and report
module router_rx_port
  import router_rx_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int BUF_DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vld_out,
  input  logic [7:0]       data_in,
  output logic             read_enb,
  output logic [7:0]       m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_sop,
  output logic             m_eop,
  output logic             pkt_done,
  output logic             parity_err,
  output logic             drop_err,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  rx_state_e        state_q, state_d;
  logic             rd_pend_q;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [7:0]       par_q, par_d;
  logic             pkt_done_q, pkt_done_d;
  logic             parity_err_q, parity_err_d;
  logic             drop_err_q, drop_err_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic       rd_req;
  logic       buf_push;
  logic       buf_pop;
  logic       buf_full;
  logic       buf_empty;
  logic       space;
  logic [1:0] buf_count;
  logic [2:0] slots_used;
  rx_entry_t  push_entry;
  rx_entry_t  head;

  router_rx_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk     (clk),
    .rst     (reset),
    .push_i  (buf_push),
    .wdata_i (push_entry),
    .pop_i   (buf_pop),
    .rdata_o (head),
    .full_o  (buf_full),
    .empty_o (buf_empty),
    .count_o (buf_count)
  );

  assign buf_pop    = m_ready & ~buf_empty;
  // a byte leaving this cycle frees its slot for a read issued this cycle
  assign slots_used = {1'b0, buf_count} + {2'b00, rd_pend_q} - {2'b00, buf_pop};
  assign space      = (slots_used < 3'd2);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  always_comb begin
    state_d      = state_q;
    rd_req       = 1'b0;
    rem_d        = rem_q;
    par_d        = par_q;
    buf_push     = 1'b0;
    push_entry   = '0;
    pkt_done_d   = 1'b0;
    parity_err_d = 1'b0;
    drop_err_d   = 1'b0;
    pkt_cnt_d    = pkt_cnt_q;
    err_cnt_d    = err_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (vld_out && space) begin
          rd_req  = 1'b1;
          state_d = HDR_WAIT;
        end
      end
      HDR_WAIT: begin
        if (rd_pend_q) begin
          buf_push        = 1'b1;
          push_entry.sop  = 1'b1;
          push_entry.eop  = (hdr_len(data_in) == '0);
          push_entry.data = data_in;
          rem_d           = hdr_len(data_in);
          par_d           = data_in;
          state_d         = (hdr_len(data_in) == '0) ? PAR_RD : PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (rd_pend_q) begin
          buf_push        = 1'b1;
          push_entry.eop  = (rem_q == '0);
          push_entry.data = data_in;
          par_d           = par_q ^ data_in;
          if (rem_q == '0) state_d = PAR_RD;
        end
        if (rem_q != '0) begin
          if (vld_out && space) begin
            rd_req = 1'b1;
            rem_d  = rem_q - 1'b1;
          end else if (!vld_out && !rd_pend_q) begin
            drop_err_d = 1'b1;
            err_cnt_d  = sat_inc(err_cnt_q);
            state_d    = IDLE;
          end
        end
      end
      PAR_RD: begin
        if (vld_out && space) begin
          rd_req  = 1'b1;
          state_d = PAR_CHK;
        end else if (!vld_out) begin
          drop_err_d = 1'b1;
          err_cnt_d  = sat_inc(err_cnt_q);
          state_d    = IDLE;
        end
      end
      PAR_CHK: begin
        if (rd_pend_q) begin
          pkt_done_d   = 1'b1;
          parity_err_d = (data_in != par_q);
          pkt_cnt_d    = sat_inc(pkt_cnt_q);
          if (data_in != par_q) err_cnt_d = sat_inc(err_cnt_q);
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      rd_pend_q    <= 1'b0;
      rem_q        <= '0;
      par_q        <= '0;
      pkt_done_q   <= 1'b0;
      parity_err_q <= 1'b0;
      drop_err_q   <= 1'b0;
      pkt_cnt_q    <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      rd_pend_q    <= rd_req;
      rem_q        <= rem_d;
      par_q        <= par_d;
      pkt_done_q   <= pkt_done_d;
      parity_err_q <= parity_err_d;
      drop_err_q   <= drop_err_d;
      pkt_cnt_q    <= pkt_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  // read_enb is combinational so it can follow vld_out; hold it low in reset
  assign read_enb   = rd_req & ~reset;
  assign m_valid    = ~buf_empty;
  assign m_data     = head.data;
  assign m_sop      = head.sop;
  assign m_eop      = head.eop;
  assign pkt_done   = pkt_done_q;
  assign parity_err = parity_err_q;
  assign drop_err   = drop_err_q;
  assign pkt_cnt    = pkt_cnt_q;
  assign err_cnt    = err_cnt_q;

  assert property (@(posedge clk) disable iff (reset) buf_full |-> !rd_pend_q);

endmodule

// File: tb/tb_router_rx_port.sv
// Scoreboard bench for router_rx_port: router FIFO model, packet-level
// reference model, and a monitor comparing forwarded bytes and status pulses.
module tb_router_rx_port;
  import router_rx_pkg::*;

  localparam int TB_CNT_W = 4;
  localparam int CMAX     = (1 << TB_CNT_W) - 1;

  logic                clk;
  logic                reset;
  logic                vld_out;
  logic [7:0]          data_in;
  logic                read_enb;
  logic [7:0]          m_data;
  logic                m_valid;
  logic                m_ready;
  logic                m_sop;
  logic                m_eop;
  logic                pkt_done;
  logic                parity_err;
  logic                drop_err;
  logic [TB_CNT_W-1:0] pkt_cnt;
  logic [TB_CNT_W-1:0] err_cnt;

  router_rx_port #(.CNT_W(TB_CNT_W), .BUF_DEPTH(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .vld_out    (vld_out),
    .data_in    (data_in),
    .read_enb   (read_enb),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_sop      (m_sop),
    .m_eop      (m_eop),
    .pkt_done   (pkt_done),
    .parity_err (parity_err),
    .drop_err   (drop_err),
    .pkt_cnt    (pkt_cnt),
    .err_cnt    (err_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int mdl_pkt = 0;
  int mdl_err = 0;
  int rdy_mode = 0;

  logic [7:0] rq[$];     // router port FIFO contents
  logic [9:0] exp_b[$];  // {sop, eop, data}
  logic [2:0] exp_ev[$]; // {pkt_done, parity_err, drop_err}
  logic [7:0] pay[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Router port FIFO: pops on read_enb, byte appears on data_in next cycle.
  initial begin
    logic re;
    vld_out = 1'b0;
    data_in = 8'h00;
    forever begin
      @(negedge clk);
      re = read_enb;
      @(posedge clk);
      #1;
      if (re) begin
        n_tests++;
        if (rq.size() == 0) begin
          n_fail++;
          $display("FAIL read_on_empty read_enb=1 with router fifo size=0");
        end else begin
          data_in = rq.pop_front();
        end
      end
      vld_out = (rq.size() != 0);
    end
  end

  int rdy_ph = 0;
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: m_ready = 1'b1;
        1: begin
          m_ready = (rdy_ph == 0);
          rdy_ph  = (rdy_ph + 1) % 4;
        end
        default: m_ready = ($urandom_range(0, 9) < 7);
      endcase
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a byte or a pulse.
  always @(negedge clk) begin
    logic [9:0] eb;
    logic [2:0] ee;
    if (!reset) begin
      if (m_valid && m_ready) begin
        n_tests++;
        if (exp_b.size() == 0) begin
          n_fail++;
          $display("FAIL out_byte unexpected sop=%0b eop=%0b data=%h, none expected",
                   m_sop, m_eop, m_data);
        end else begin
          eb = exp_b.pop_front();
          if ({m_sop, m_eop, m_data} !== eb) begin
            n_fail++;
            $display("FAIL out_byte got sop=%0b eop=%0b data=%h exp sop=%0b eop=%0b data=%h",
                     m_sop, m_eop, m_data, eb[9], eb[8], eb[7:0]);
          end
        end
      end
      if (pkt_done || parity_err || drop_err) begin
        n_tests++;
        if (exp_ev.size() == 0) begin
          n_fail++;
          $display("FAIL status unexpected done=%0b perr=%0b drop=%0b",
                   pkt_done, parity_err, drop_err);
        end else begin
          ee = exp_ev.pop_front();
          if ({pkt_done, parity_err, drop_err} !== ee) begin
            n_fail++;
            $display("FAIL status got done/perr/drop=%b exp=%b",
                     {pkt_done, parity_err, drop_err}, ee);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic fill_random(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom_range(0, 255)));
  endtask

  // par_mode: 0 correct parity, 1 forced byte force_val, 2 random corruption.
  // cut >= 0: router soft-reset after cut payload bytes (packet aborted).
  task automatic send_pkt(input logic [7:0] hdr, input int par_mode,
                          input logic [7:0] force_val, input int cut);
    int         len;
    int         nfwd;
    logic [7:0] par;
    logic [7:0] pbyte;
    logic       bad;
    len  = int'(hdr[7:2]);
    nfwd = (cut < 0) ? len : cut;
    par  = hdr;
    for (int i = 0; i < len; i++) par = par ^ pay[i];
    case (par_mode)
      0:       pbyte = par;
      1:       pbyte = force_val;
      default: pbyte = par ^ 8'($urandom_range(1, 255));
    endcase
    bad = (pbyte != par);
    exp_b.push_back({1'b1, (cut < 0) && (len == 0), hdr});
    for (int i = 0; i < nfwd; i++)
      exp_b.push_back({1'b0, (cut < 0) && (i == len - 1), pay[i]});
    if (cut < 0) begin
      exp_ev.push_back({1'b1, bad, 1'b0});
      mdl_pkt = sat(mdl_pkt);
      if (bad) mdl_err = sat(mdl_err);
    end else begin
      exp_ev.push_back(3'b001);
      mdl_err = sat(mdl_err);
    end
    rq.push_back(hdr);
    for (int i = 0; i < nfwd; i++) rq.push_back(pay[i]);
    if (cut < 0) rq.push_back(pbyte);
  endtask

  task automatic drain(input string tag);
    int cyc;
    cyc = 0;
    while ((exp_b.size() != 0 || exp_ev.size() != 0 || rq.size() != 0) && cyc < 5000) begin
      @(posedge clk);
      cyc++;
    end
    n_tests++;
    if (cyc >= 5000) begin
      n_fail++;
      $display("FAIL %s drain_timeout bytes_left=%0d events_left=%0d router_left=%0d",
               tag, exp_b.size(), exp_ev.size(), rq.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_pkt_cnt"}, 64'(pkt_cnt), 64'(mdl_pkt));
    chk({tag, "_err_cnt"}, 64'(err_cnt), 64'(mdl_err));
  endtask

  initial begin
    int cyc;
    int len;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs",
        64'({read_enb, m_valid, m_sop, m_eop, m_data, pkt_done, parity_err, drop_err,
             pkt_cnt, err_cnt}), 64'd0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 1: good packet, len 3
    rdy_mode = 0;
    pay.delete();
    pay.push_back(8'h11); pay.push_back(8'h22); pay.push_back(8'h33);
    send_pkt(8'h0D, 0, 8'h00, -1);
    drain("t1");
    chk_counters("t1");

    // 2: same packet, parity byte forced to 00
    send_pkt(8'h0D, 1, 8'h00, -1);
    drain("t2");
    chk_counters("t2");

    // 3: zero-length packet
    pay.delete();
    send_pkt(8'h00, 1, 8'h00, -1);
    drain("t3");
    chk_counters("t3");

    // 4: len 20 with sink ready 1 cycle in 4
    rdy_mode = 1;
    fill_random(20);
    send_pkt({6'd20, 2'b01}, 0, 8'h00, -1);
    drain("t4");
    chk_counters("t4");

    // 5: abort after 4 of 10 payload bytes, then a normal packet
    rdy_mode = 0;
    fill_random(10);
    send_pkt({6'd10, 2'b10}, 0, 8'h00, 4);
    drain("t5_abort");
    chk_counters("t5_abort");
    chk("t5_idle_quiet", 64'({read_enb, m_valid}), 64'd0);
    fill_random(5);
    send_pkt({6'd5, 2'b00}, 0, 8'h00, -1);
    drain("t5_next");
    chk_counters("t5_next");

    // 6: reset in the middle of a payload
    rdy_mode = 2;
    fill_random(20);
    send_pkt({6'd20, 2'b11}, 0, 8'h00, -1);
    cyc = 0;
    while (exp_b.size() > 16 && cyc < 2000) begin
      @(posedge clk);
      cyc++;
    end
    chk("t6_reached_payload", 64'(cyc < 2000), 64'd1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    exp_b.delete();
    exp_ev.delete();
    rq.delete();
    mdl_pkt = 0;
    mdl_err = 0;
    #1;
    chk("t6_reset_outputs",
        64'({read_enb, m_valid, m_sop, m_eop, m_data, pkt_done, parity_err, drop_err,
             pkt_cnt, err_cnt}), 64'd0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    rdy_mode = 0;
    fill_random(7);
    send_pkt({6'd7, 2'b01}, 0, 8'h00, -1);
    drain("t6_after");
    chk_counters("t6_after");

    // random traffic; enough packets to saturate the 4-bit counters
    rdy_mode = 2;
    for (int k = 0; k < 25; k++) begin
      len = (k % 9 == 8) ? 63 : int'($urandom_range(0, 12));
      fill_random(len);
      send_pkt({6'(len), 2'($urandom_range(0, 3))},
               ($urandom_range(0, 3) == 0) ? 2 : 0, 8'h00, -1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    drain("rand");
    chk_counters("rand");
    chk("rand_pkt_saturated", 64'(pkt_cnt), 64'(CMAX));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
